hamming_dec_arbiter: RTL and testbench

- Shares one combinational Hamming(7,4) decoder (syndrome plus corrected data) between two requesters.
- Typical requesters: the switch/button capture path and a self-test pattern source.
- Round-robin grant, valid/ready handshakes on the request and response sides, registered decoder input, configurable decoder settle time.
- Sits between the input capture logic and the LED / 7-segment display drivers.

---
 rtl/hamming_dec_arbiter.sv | 169 ++++++++++++++++
 tb/tb_hamming_dec_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_dec_arbiter.sv
// Round-robin sharing of one external combinational Hamming(7,4) decoder between two requesters.
// Define HAM_ARB_STATS_EN to add saturating per-requester nonzero-syndrome counters (err_cnt0/err_cnt1).
module hamming_dec_arbiter #(
    parameter int DEC_LAT = 1,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [6:0]       req0_word,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [6:0]       req1_word,
    output logic             req1_ready,
    output logic [6:0]       dec_word,
    input  logic [2:0]       dec_sindrome,
    input  logic [3:0]       dec_data,
    output logic             rsp0_valid,
    output logic [3:0]       rsp0_data,
    output logic [2:0]       rsp0_sindrome,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    output logic [3:0]       rsp1_data,
    output logic [2:0]       rsp1_sindrome,
    input  logic             rsp1_ready,
    output logic             busy
`ifdef HAM_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0] err_cnt0,
    output logic [CNT_W-1:0] err_cnt1
`endif
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // dec_word only lands on the handshake edge, so the settle window closes
    // DEC_LAT edges after that and the capture happens on the following edge.
    localparam logic [2:0] WAIT_INIT = 3'(DEC_LAT);

    if (DEC_LAT < 1 || DEC_LAT > 4) begin : g_bad_dec_lat
        $error("hamming_dec_arbiter: DEC_LAT=%0d is outside 1..4", DEC_LAT);
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("hamming_dec_arbiter: CNT_W=%0d must be at least 1", CNT_W);
    end

    logic [1:0] state_reg, state_next;
    logic       last_reg;
    logic       owner_reg;
    logic [2:0] wait_cnt_reg;
    logic [6:0] dec_word_reg;
    logic       busy_reg;
    logic       grant;
    logic       capture;
    logic       release_rsp;
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic [1:0] rsp_ready;

    assign req_valid = {req1_valid, req0_valid};
    assign rsp_ready = {rsp1_ready, rsp0_ready};

    // On a tie the requester that was not served last wins.
    always_comb begin
        grant = 1'b0;
        if (req_valid == 2'b10) begin
            grant = 1'b1;
        end else if (req_valid == 2'b11) begin
            grant = ~last_reg;
        end
    end

    assign req_ready[0] = rst_n & (state_reg == ST_IDLE) & req_valid[0] & ~grant;
    assign req_ready[1] = rst_n & (state_reg == ST_IDLE) & req_valid[1] &  grant;
    assign req0_ready   = req_ready[0];
    assign req1_ready   = req_ready[1];

    assign capture     = (state_reg == ST_WAIT) && (wait_cnt_reg == 3'd0);
    assign release_rsp = (state_reg == ST_RESP) && rsp_ready[owner_reg];

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (|req_ready) state_next = ST_WAIT;
            ST_WAIT: if (capture) state_next = ST_RESP;
            ST_RESP: if (release_rsp) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            last_reg     <= 1'b1;
            owner_reg    <= 1'b0;
            wait_cnt_reg <= 3'd0;
            dec_word_reg <= 7'd0;
            busy_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            busy_reg  <= (state_next != ST_IDLE);
            if (|req_ready) begin
                dec_word_reg <= grant ? req1_word : req0_word;
                owner_reg    <= grant;
                wait_cnt_reg <= WAIT_INIT;
            end else if (state_reg == ST_WAIT && wait_cnt_reg != 3'd0) begin
                wait_cnt_reg <= wait_cnt_reg - 3'd1;
            end
            if (release_rsp) begin
                last_reg <= owner_reg;
            end
        end
    end

    assign dec_word = dec_word_reg;
    assign busy     = busy_reg;

    genvar gi;
    for (gi = 0; gi < 2; gi++) begin : g_rsp
        logic       rsp_valid_reg;
        logic [3:0] rsp_data_reg;
        logic [2:0] rsp_sind_reg;
        logic       own;

        assign own = (owner_reg == 1'(gi));

        // The non-owner's data/syndrome keep their last captured values.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rsp_valid_reg <= 1'b0;
                rsp_data_reg  <= 4'd0;
                rsp_sind_reg  <= 3'd0;
            end else if (capture && own) begin
                rsp_valid_reg <= 1'b1;
                rsp_data_reg  <= dec_data;
                rsp_sind_reg  <= dec_sindrome;
            end else if (release_rsp && own) begin
                rsp_valid_reg <= 1'b0;
            end
        end

`ifdef HAM_ARB_STATS_EN
        logic [CNT_W-1:0] err_cnt_reg;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                err_cnt_reg <= '0;
            end else if (capture && own && dec_sindrome != 3'd0 && err_cnt_reg != '1) begin
                err_cnt_reg <= err_cnt_reg + CNT_W'(1);
            end
        end
`endif
    end

    assign rsp0_valid    = g_rsp[0].rsp_valid_reg;
    assign rsp0_data     = g_rsp[0].rsp_data_reg;
    assign rsp0_sindrome = g_rsp[0].rsp_sind_reg;
    assign rsp1_valid    = g_rsp[1].rsp_valid_reg;
    assign rsp1_data     = g_rsp[1].rsp_data_reg;
    assign rsp1_sindrome = g_rsp[1].rsp_sind_reg;

`ifdef HAM_ARB_STATS_EN
    assign err_cnt0 = g_rsp[0].err_cnt_reg;
    assign err_cnt1 = g_rsp[1].err_cnt_reg;
`endif

endmodule

// File: tb/tb_hamming_dec_arbiter.sv
// Directed bench: instance A (DEC_LAT=1) for arbitration/backpressure, instance B (DEC_LAT=3, CNT_W=2)
// for settle latency, mid-transaction reset and counter saturation. Each instance drives a decoder model.
module tb_hamming_dec_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // External decoder: syndrome {c2,c1,c0} names the flipped bit position (1..7).
    function automatic logic [6:0] ham_decode(input logic [6:0] w);
        logic [2:0] syn;
        logic [6:0] fixed;
        syn[0] = w[0] ^ w[2] ^ w[4] ^ w[6];
        syn[1] = w[1] ^ w[2] ^ w[5] ^ w[6];
        syn[2] = w[3] ^ w[4] ^ w[5] ^ w[6];
        fixed  = w;
        if (syn != 3'd0) fixed[syn - 3'd1] = ~fixed[syn - 3'd1];
        return {syn, fixed[6], fixed[5], fixed[4], fixed[2]};
    endfunction

    // Instance A signals
    logic       a_rst_n, a_req0_valid, a_req0_ready, a_req1_valid, a_req1_ready;
    logic [6:0] a_req0_word, a_req1_word, a_dec_word;
    logic [2:0] a_dec_sind, a_rsp0_sind, a_rsp1_sind;
    logic [3:0] a_dec_data, a_rsp0_data, a_rsp1_data;
    logic       a_rsp0_valid, a_rsp0_ready, a_rsp1_valid, a_rsp1_ready, a_busy;
    // Instance B signals
    logic       b_rst_n, b_req0_valid, b_req0_ready, b_req1_valid, b_req1_ready;
    logic [6:0] b_req0_word, b_req1_word, b_dec_word;
    logic [2:0] b_dec_sind, b_rsp0_sind, b_rsp1_sind;
    logic [3:0] b_dec_data, b_rsp0_data, b_rsp1_data;
    logic       b_rsp0_valid, b_rsp0_ready, b_rsp1_valid, b_rsp1_ready, b_busy;
`ifdef HAM_ARB_STATS_EN
    logic [7:0] a_err_cnt0, a_err_cnt1;
    logic [1:0] b_err_cnt0, b_err_cnt1;
`endif

    assign {a_dec_sind, a_dec_data} = ham_decode(a_dec_word);
    assign {b_dec_sind, b_dec_data} = ham_decode(b_dec_word);

    hamming_dec_arbiter #(.DEC_LAT(1), .CNT_W(8)) u_dut_a (
        .clk(clk), .rst_n(a_rst_n),
        .req0_valid(a_req0_valid), .req0_word(a_req0_word), .req0_ready(a_req0_ready),
        .req1_valid(a_req1_valid), .req1_word(a_req1_word), .req1_ready(a_req1_ready),
        .dec_word(a_dec_word), .dec_sindrome(a_dec_sind), .dec_data(a_dec_data),
        .rsp0_valid(a_rsp0_valid), .rsp0_data(a_rsp0_data), .rsp0_sindrome(a_rsp0_sind),
        .rsp0_ready(a_rsp0_ready),
        .rsp1_valid(a_rsp1_valid), .rsp1_data(a_rsp1_data), .rsp1_sindrome(a_rsp1_sind),
        .rsp1_ready(a_rsp1_ready),
        .busy(a_busy)
`ifdef HAM_ARB_STATS_EN
        , .err_cnt0(a_err_cnt0), .err_cnt1(a_err_cnt1)
`endif
    );

    hamming_dec_arbiter #(.DEC_LAT(3), .CNT_W(2)) u_dut_b (
        .clk(clk), .rst_n(b_rst_n),
        .req0_valid(b_req0_valid), .req0_word(b_req0_word), .req0_ready(b_req0_ready),
        .req1_valid(b_req1_valid), .req1_word(b_req1_word), .req1_ready(b_req1_ready),
        .dec_word(b_dec_word), .dec_sindrome(b_dec_sind), .dec_data(b_dec_data),
        .rsp0_valid(b_rsp0_valid), .rsp0_data(b_rsp0_data), .rsp0_sindrome(b_rsp0_sind),
        .rsp0_ready(b_rsp0_ready),
        .rsp1_valid(b_rsp1_valid), .rsp1_data(b_rsp1_data), .rsp1_sindrome(b_rsp1_sind),
        .rsp1_ready(b_rsp1_ready),
        .busy(b_busy)
`ifdef HAM_ARB_STATS_EN
        , .err_cnt0(b_err_cnt0), .err_cnt1(b_err_cnt1)
`endif
    );

    // One request on B's port 0; returns the response and edges from handshake to rsp0_valid.
    task automatic b_req0_txn(input logic [6:0] w, output logic [3:0] d, output logic [2:0] s,
                              output int lat);
        int n = 0;
        b_req0_word  = w;
        b_req0_valid = 1'b1;
        #1;
        while (!b_req0_ready && n < 10) begin
            step();
            n++;
        end
        check("b_req0_ready", 32'(b_req0_ready), 32'd1);
        step();
        b_req0_valid = 1'b0;
        b_req0_word  = ~w;
        b_req1_valid = 1'b1;
        lat = 0;
        while (!b_rsp0_valid && lat < 10) begin
            check("b_dec_word_hold", 32'(b_dec_word), 32'(w));
            check("b_req1_blocked", 32'(b_req1_ready), 32'd0);
            b_req1_word = 7'($urandom);
            step();
            lat++;
        end
        d = b_rsp0_data;
        s = b_rsp0_sind;
        b_req1_valid = 1'b0;
        b_rsp0_ready = 1'b1;
        step();
        b_rsp0_ready = 1'b0;
        check("b_rsp0_cleared", 32'(b_rsp0_valid), 32'd0);
        $display("[TB] txn B req0 word=%b lat=%0d data=%b syn=%b", w, lat, d, s);
    endtask

    initial begin
        logic [3:0] d;
        logic [2:0] s;
        int         lat;
        int         n;
        logic [6:0] cont_word [2];
        logic [3:0] cont_data [2];
        logic [2:0] cont_sind [2];

        cont_word[0] = 7'b0010011; cont_data[0] = 4'b0110; cont_sind[0] = 3'b110;
        cont_word[1] = 7'b0010010; cont_data[1] = 4'b1010; cont_sind[1] = 3'b111;

        a_rst_n = 1'b0; b_rst_n = 1'b0;
        a_req0_valid = 1'b1; a_req0_word = 7'h55; a_req1_valid = 1'b0; a_req1_word = 7'd0;
        a_rsp0_ready = 1'b0; a_rsp1_ready = 1'b0;
        b_req0_valid = 1'b1; b_req0_word = 7'h2a; b_req1_valid = 1'b0; b_req1_word = 7'd0;
        b_rsp0_ready = 1'b0; b_rsp1_ready = 1'b0;
        step();
        step();

        // Reset state
        check("rst_a_req0_ready", 32'(a_req0_ready), 32'd0);
        check("rst_a_busy", 32'(a_busy), 32'd0);
        check("rst_a_dec_word", 32'(a_dec_word), 32'd0);
        check("rst_a_rsp", {a_rsp0_valid, a_rsp1_valid, a_rsp0_data, a_rsp0_sind}, 32'd0);
        check("rst_b_req0_ready", 32'(b_req0_ready), 32'd0);
        a_req0_valid = 1'b0;
        b_req0_valid = 1'b0;
        a_rst_n = 1'b1;
        b_rst_n = 1'b1;
        step();

        // Single erroneous word on A port 0
        a_req0_word  = 7'b1110110;
        a_req0_valid = 1'b1;
        #1;
        check("t1_req0_ready", 32'(a_req0_ready), 32'd1);
        check("t1_req1_ready", 32'(a_req1_ready), 32'd0);
        step();
        a_req0_valid = 1'b0;
        check("t1_dec_word", 32'(a_dec_word), 32'b1110110);
        check("t1_busy", 32'(a_busy), 32'd1);
        check("t1_rsp_early0", 32'(a_rsp0_valid), 32'd0);
        step();
        check("t1_rsp_early1", 32'(a_rsp0_valid), 32'd0);
        step();
        check("t1_rsp_valid", 32'(a_rsp0_valid), 32'd1);
        check("t1_rsp1_valid", 32'(a_rsp1_valid), 32'd0);
        check("t1_data", 32'(a_rsp0_data), 32'b1101);
        check("t1_sind", 32'(a_rsp0_sind), 32'b101);
`ifdef HAM_ARB_STATS_EN
        check("t1_err_cnt0", 32'(a_err_cnt0), 32'd1);
`endif
        $display("[TB] txn A req0 word=1110110 data=%b syn=%b", a_rsp0_data, a_rsp0_sind);
        a_rsp0_ready = 1'b1;
        step();
        a_rsp0_ready = 1'b0;
        check("t1_rsp_clear", 32'(a_rsp0_valid), 32'd0);
        check("t1_idle", 32'(a_busy), 32'd0);

        // Clean word on A port 1
        a_req1_word  = 7'b1100110;
        a_req1_valid = 1'b1;
        #1;
        check("t2_req1_ready", 32'(a_req1_ready), 32'd1);
        step();
        a_req1_valid = 1'b0;
        step();
        step();
        check("t2_rsp_valid", 32'(a_rsp1_valid), 32'd1);
        check("t2_data", 32'(a_rsp1_data), 32'b1101);
        check("t2_sind", 32'(a_rsp1_sind), 32'b000);
        check("t2_rsp0_hold", {a_rsp0_valid, a_rsp0_data, a_rsp0_sind}, {1'b0, 4'b1101, 3'b101});
`ifdef HAM_ARB_STATS_EN
        check("t2_err_cnt1", 32'(a_err_cnt1), 32'd0);
        check("t2_err_cnt0", 32'(a_err_cnt0), 32'd1);
`endif
        $display("[TB] txn A req1 word=1100110 data=%b syn=%b", a_rsp1_data, a_rsp1_sind);
        a_rsp1_ready = 1'b1;
        step();
        a_rsp1_ready = 1'b0;

        // Contention: both held valid, grants must alternate 0,1,0,1
        a_req0_word = cont_word[0];
        a_req1_word = cont_word[1];
        a_req0_valid = 1'b1;
        a_req1_valid = 1'b1;
        a_rsp0_ready = 1'b1;
        a_rsp1_ready = 1'b1;
        for (int t = 0; t < 4; t++) begin
            n = 0;
            while (!(a_rsp0_valid || a_rsp1_valid) && n < 20) begin
                check("t3_ready_onehot", 32'(a_req0_ready & a_req1_ready), 32'd0);
                step();
                n++;
            end
            check("t3_owner", 32'(a_rsp1_valid), 32'(t % 2));
            check("t3_both_valid", 32'(a_rsp0_valid & a_rsp1_valid), 32'd0);
            check("t3_sind", 32'(a_rsp1_valid ? a_rsp1_sind : a_rsp0_sind), 32'(cont_sind[t % 2]));
            check("t3_data", 32'(a_rsp1_valid ? a_rsp1_data : a_rsp0_data), 32'(cont_data[t % 2]));
            $display("[TB] txn A contention #%0d rsp1=%0d data=%b syn=%b", t, a_rsp1_valid,
                     a_rsp1_valid ? a_rsp1_data : a_rsp0_data,
                     a_rsp1_valid ? a_rsp1_sind : a_rsp0_sind);
            step();
        end
        a_req0_valid = 1'b0;
        a_req1_valid = 1'b0;
        a_rsp0_ready = 1'b0;
        a_rsp1_ready = 1'b0;

        // Backpressure on rsp0 while requester 1 keeps asking
        a_req0_word  = 7'b1110110;
        a_req0_valid = 1'b1;
        a_req1_word  = 7'b0000000;
        a_req1_valid = 1'b1;
        #1;
        check("t4_grant0", {a_req0_ready, a_req1_ready}, 32'b10);
        step();
        a_req0_valid = 1'b0;
        n = 0;
        while (!a_rsp0_valid && n < 10) begin
            step();
            n++;
        end
        for (int k = 0; k < 5; k++) begin
            check("t4_hold_valid", 32'(a_rsp0_valid), 32'd1);
            check("t4_hold_data", {a_rsp0_data, a_rsp0_sind}, {4'b1101, 3'b101});
            check("t4_busy", 32'(a_busy), 32'd1);
            check("t4_req1_ready", 32'(a_req1_ready), 32'd0);
            a_req1_word = 7'($urandom);
            step();
        end
        a_rsp0_ready = 1'b1;
        step();
        a_rsp0_ready = 1'b0;
        check("t4_release_idle", 32'(a_busy), 32'd0);
        check("t4_release_valid", 32'(a_rsp0_valid), 32'd0);
        check("t4_req1_now_ready", 32'(a_req1_ready), 32'd1);
        check("t4_rsp1_kept", {a_rsp1_data, a_rsp1_sind}, {4'b1010, 3'b111});
        a_req1_valid = 1'b0;
        $display("[TB] txn A req0 backpressured word=1110110 released");

        // DEC_LAT=3 on instance B
        b_req0_txn(7'b0010011, d, s, lat);
        check("b1_lat", 32'(lat), 32'd4);
        check("b1_data", 32'(d), 32'b0110);
        check("b1_sind", 32'(s), 32'b110);
`ifdef HAM_ARB_STATS_EN
        check("b1_err_cnt0", 32'(b_err_cnt0), 32'd1);
`endif

        // Reset pulse in WAIT aborts the transaction
        b_req1_word  = 7'b1100110;
        b_req1_valid = 1'b1;
        #1;
        check("b2_req1_ready", 32'(b_req1_ready), 32'd1);
        step();
        b_req1_valid = 1'b0;
        step();
        check("b2_in_wait", 32'(b_busy), 32'd1);
        b_req0_valid = 1'b1;
        b_rst_n = 1'b0;
        #1;
        check("b2_rst_busy", 32'(b_busy), 32'd0);
        check("b2_rst_dec_word", 32'(b_dec_word), 32'd0);
        check("b2_rst_rsp", {b_rsp0_valid, b_rsp1_valid, b_rsp0_data, b_rsp0_sind, b_rsp1_data,
                             b_rsp1_sind}, 32'd0);
        check("b2_rst_ready", 32'(b_req0_ready), 32'd0);
`ifdef HAM_ARB_STATS_EN
        check("b2_rst_err_cnt0", 32'(b_err_cnt0), 32'd0);
`endif
        step();
        b_req0_valid = 1'b0;
        b_rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            check("b2_no_stale_rsp", {b_rsp0_valid, b_rsp1_valid, b_busy}, 32'd0);
        end
        $display("[TB] txn B req1 aborted by reset");

        b_req0_txn(7'b1100110, d, s, lat);
        check("b3_lat", 32'(lat), 32'd4);
        check("b3_data", 32'(d), 32'b1101);
        check("b3_sind", 32'(s), 32'b000);
`ifdef HAM_ARB_STATS_EN
        check("b3_err_cnt0", 32'(b_err_cnt0), 32'd0);
`endif

        // Five erroneous words: a 2-bit counter must stick at 3
        for (int k = 1; k <= 5; k++) begin
            b_req0_txn(7'b1110110, d, s, lat);
            check("b4_data", {d, s}, {4'b1101, 3'b101});
`ifdef HAM_ARB_STATS_EN
            check("b4_err_cnt0", 32'(b_err_cnt0), (k < 3) ? 32'(k) : 32'd3);
`endif
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
